// File: rtl/gon_opsum_collector.sv
// GON opsum collector: scan-loaded per-PE X/Y ID tables, lowest-index tag match,
// single-word output buffer with an EMPTY/FULL/DRAIN handshake toward the controller.
module gon_opsum_collector #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 4,
  parameter int YID_BITS    = 3,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       set_XID,
  input  logic [XID_BITS-1:0]                        opsum_XID_scan_in,
  input  logic                                       set_YID,
  input  logic [YID_BITS-1:0]                        opsum_YID_scan_in,
  input  logic [XID_BITS-1:0]                        opsum_tag_X,
  input  logic [YID_BITS-1:0]                        opsum_tag_Y,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_opsum_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_SIZE-1:0] PE_opsum_data,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_opsum_ready,
  output logic                                       GLB_opsum_valid,
  input  logic                                       GLB_opsum_ready,
  output logic [DATA_SIZE-1:0]                       PE_data_out,
  output logic                                       multi_match
);

  localparam int NUM_PE = NUMS_PE_ROW * NUMS_PE_COL;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [XID_BITS-1:0]   xid_r [NUM_PE];
  logic [YID_BITS-1:0]   yid_r [NUMS_PE_ROW];
  logic [NUM_PE-1:0]     match_s;
  logic [NUM_PE-1:0]     sel_s;
  logic [DATA_SIZE-1:0]  sel_data_s;
  logic [DATA_SIZE-1:0]  data_r;
  logic                  multi_r;
  logic                  accept_s;

  function automatic logic [NUM_PE-1:0] lowest_one(input logic [NUM_PE-1:0] v);
    return v & (~v + {{(NUM_PE-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic more_than_one(input logic [NUM_PE-1:0] v);
    return |(v & (v - {{(NUM_PE-1){1'b0}}, 1'b1}));
  endfunction

  // ID scan chains: new value enters the top entry, everything moves one toward entry 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PE; k++) xid_r[k] <= '0;
      for (int j = 0; j < NUMS_PE_ROW; j++) yid_r[j] <= '0;
    end else begin
      if (set_XID) begin
        for (int k = 0; k < NUM_PE-1; k++) xid_r[k] <= xid_r[k+1];
        xid_r[NUM_PE-1] <= opsum_XID_scan_in;
      end
      if (set_YID) begin
        for (int j = 0; j < NUMS_PE_ROW-1; j++) yid_r[j] <= yid_r[j+1];
        yid_r[NUMS_PE_ROW-1] <= opsum_YID_scan_in;
      end
    end
  end

  // Tag match per PE, lowest-index winner and its data word
  always_comb begin
    match_s    = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      match_s[i] = PE_opsum_valid[i] && (xid_r[i] == opsum_tag_X) &&
                   (yid_r[i / NUMS_PE_COL] == opsum_tag_Y);
    end
    sel_s = lowest_one(match_s);
    for (int i = 0; i < NUM_PE; i++) begin
      sel_data_s = sel_data_s | ({DATA_SIZE{sel_s[i]}} & PE_opsum_data[i*DATA_SIZE +: DATA_SIZE]);
    end
  end

  // Buffer next-state; the tag is only looked at while EMPTY
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      EMPTY: begin
        if ((|match_s) && !rst) begin
          accept_s    = 1'b1;
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (GLB_opsum_ready) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FULL;
        end
      end
      DRAIN:   state_nxt_s = EMPTY;
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, buffered word and sticky multi-match flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
      data_r  <= '0;
      multi_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        data_r <= sel_data_s;
        if (more_than_one(match_s)) multi_r <= 1'b1;
      end
    end
  end

  assign PE_opsum_ready  = accept_s ? sel_s : '0;
  assign GLB_opsum_valid = (state_r == FULL);
  assign PE_data_out     = data_r;
  assign multi_match     = multi_r;

endmodule

// File: tb/tb_gon_opsum_collector.sv
// Randomized and directed bench for gon_opsum_collector against a queue-based reference model.
module tb_gon_opsum_collector;

  localparam int ROW = 6;
  localparam int COL = 8;
  localparam int NPE = ROW * COL;

  logic              clk;
  logic              rst;
  logic              set_xid;
  logic [3:0]        xscan;
  logic              set_yid;
  logic [2:0]        yscan;
  logic [3:0]        tag_x;
  logic [2:0]        tag_y;
  logic [NPE-1:0]    pe_valid;
  logic [NPE*32-1:0] pe_data_bus;
  logic [31:0]       pe_word [NPE];
  logic [NPE-1:0]    PE_opsum_ready;
  logic              GLB_opsum_valid;
  logic              glb_ready;
  logic [31:0]       PE_data_out;
  logic              multi_match;

  int checks = 0;
  int errors = 0;

  int          xq[$];
  int          yq[$];
  bit          m_full;
  bit          m_bubble;
  bit          m_multi;
  logic [31:0] m_data;
  int          acc_idx;

  logic [NPE-1:0] last_ready;
  logic           last_valid;
  logic [31:0]    last_data;
  logic           last_multi;

  gon_opsum_collector dut (
    .clk               (clk),
    .rst               (rst),
    .set_XID           (set_xid),
    .opsum_XID_scan_in (xscan),
    .set_YID           (set_yid),
    .opsum_YID_scan_in (yscan),
    .opsum_tag_X       (tag_x),
    .opsum_tag_Y       (tag_y),
    .PE_opsum_valid    (pe_valid),
    .PE_opsum_data     (pe_data_bus),
    .PE_opsum_ready    (PE_opsum_ready),
    .GLB_opsum_valid   (GLB_opsum_valid),
    .GLB_opsum_ready   (glb_ready),
    .PE_data_out       (PE_data_out),
    .multi_match       (multi_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    pe_data_bus = '0;
    for (int i = 0; i < NPE; i++) pe_data_bus[i*32 +: 32] = pe_word[i];
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    xq = {};
    yq = {};
    for (int i = 0; i < NPE; i++) xq.push_back(0);
    for (int j = 0; j < ROW; j++) yq.push_back(0);
    m_full   = 1'b0;
    m_bubble = 1'b0;
    m_multi  = 1'b0;
    m_data   = 32'h0;
  endtask

  // One clock: check outputs, advance model on the edge, retire the accepted PE word.
  task automatic step();
    logic [NPE-1:0] exp_ready;
    int nmatch;
    #1;
    if (rst) model_reset();
    exp_ready = '0;
    nmatch    = 0;
    acc_idx   = -1;
    if (!rst && !m_full && !m_bubble) begin
      for (int i = 0; i < NPE; i++) begin
        if (pe_valid[i] && xq[i] == int'(tag_x) && yq[i / COL] == int'(tag_y)) begin
          if (nmatch == 0) acc_idx = i;
          nmatch++;
        end
      end
    end
    if (acc_idx >= 0) exp_ready[acc_idx] = 1'b1;
    check_val("pe_ready", {16'h0, PE_opsum_ready}, {16'h0, exp_ready});
    check_val("glb_valid", {63'h0, GLB_opsum_valid}, {63'h0, m_full});
    if (m_full || rst) check_val("data_out", {32'h0, PE_data_out}, {32'h0, m_data});
    check_val("multi_match", {63'h0, multi_match}, {63'h0, m_multi});
    last_ready = PE_opsum_ready;
    last_valid = GLB_opsum_valid;
    last_data  = PE_data_out;
    last_multi = multi_match;
    @(posedge clk);
    if (!rst) begin
      if (set_xid) begin xq.push_back(int'(xscan)); void'(xq.pop_front()); end
      if (set_yid) begin yq.push_back(int'(yscan)); void'(yq.pop_front()); end
      if (m_full) begin
        if (glb_ready) begin m_full = 1'b0; m_bubble = 1'b1; end
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (acc_idx >= 0) begin
        m_full = 1'b1;
        m_data = pe_word[acc_idx];
        if (nmatch > 1) m_multi = 1'b1;
      end
    end
    @(negedge clk);
    if (acc_idx >= 0 && !rst) pe_valid[acc_idx] = 1'b0;
  endtask

  task automatic flush();
    glb_ready = 1'b1;
    repeat (4) step();
    glb_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; set_xid = 1'b0; xscan = 4'h0; set_yid = 1'b0; yscan = 3'h0;
    tag_x = 4'h0; tag_y = 3'h0; pe_valid = '0; glb_ready = 1'b0;
    for (int i = 0; i < NPE; i++) pe_word[i] = 32'h0;
    model_reset();
    repeat (2) step();
    check_val("rst_valid", {63'h0, last_valid}, 64'h0);
    check_val("rst_data", {32'h0, last_data}, 64'h0);
    rst = 1'b0;

    // Load X = index mod 16, Y rows 0..5
    for (int i = 0; i < NPE; i++) begin
      set_xid = 1'b1; xscan = 4'(i % 16);
      set_yid = (i < ROW); yscan = 3'(i % 8);
      step();
    end
    set_xid = 1'b0; set_yid = 1'b0;

    // Basic accept of PE 5, then backpressure
    tag_x = 4'd5; tag_y = 3'd0;
    pe_valid[5] = 1'b1; pe_word[5] = 32'hDEADBEEF;
    step();
    check_val("tp_ready5", {16'h0, last_ready}, 64'h20);
    pe_valid[5] = 1'b1; pe_word[5] = 32'hCAFEF00D;
    step();
    check_val("tp_valid", {63'h0, last_valid}, 64'h1);
    check_val("tp_data", {32'h0, last_data}, 64'hDEADBEEF);
    repeat (9) step();
    check_val("bp_data", {32'h0, last_data}, 64'hDEADBEEF);
    glb_ready = 1'b1;
    step();
    glb_ready = 1'b0;
    step();
    check_val("drain_no_accept", {16'h0, last_ready}, 64'h0);
    step();
    check_val("reaccept5", {16'h0, last_ready}, 64'h20);
    flush();

    // Rows all YID 0, two matches on PEs 3 and 19
    set_yid = 1'b1; yscan = 3'd0;
    repeat (ROW) step();
    set_yid = 1'b0;
    tag_x = 4'd3; tag_y = 3'd0;
    pe_valid[3] = 1'b1; pe_word[3] = 32'h00000003;
    pe_valid[19] = 1'b1; pe_word[19] = 32'h00000019;
    glb_ready = 1'b1;
    step();
    check_val("multi_first3", {16'h0, last_ready}, 64'h8);
    step();
    check_val("multi_flag", {63'h0, last_multi}, 64'h1);
    step();
    step();
    check_val("multi_then19", {16'h0, last_ready}, 64'h80000);
    flush();

    // Mismatched tag: PE 6 must not be taken
    tag_x = 4'd7; tag_y = 3'd0;
    pe_valid[6] = 1'b1; pe_word[6] = 32'h66666666;
    repeat (4) step();
    check_val("mismatch_ready", {16'h0, last_ready}, 64'h0);
    check_val("mismatch_valid", {63'h0, last_valid}, 64'h0);
    pe_valid[6] = 1'b0;

    // Tag change on the transfer edge
    tag_x = 4'd1; tag_y = 3'd0;
    pe_valid[1] = 1'b1; pe_word[1] = 32'h11111111;
    step();
    step();
    glb_ready = 1'b1; tag_x = 4'd2; pe_valid[2] = 1'b1; pe_word[2] = 32'h22222222;
    step();
    glb_ready = 1'b0;
    step();
    check_val("tagchg_drain", {16'h0, last_ready}, 64'h0);
    step();
    check_val("tagchg_accept", {16'h0, last_ready}, 64'h4);
    flush();

    // Reset while FULL
    tag_x = 4'd1; tag_y = 3'd0;
    pe_valid[1] = 1'b1; pe_word[1] = 32'h12345678;
    step();
    step();
    check_val("full_before_rst", {32'h0, last_data}, 64'h12345678);
    rst = 1'b1;
    step();
    check_val("rst_mid_valid", {63'h0, last_valid}, 64'h0);
    check_val("rst_mid_data", {32'h0, last_data}, 64'h0);
    rst = 1'b0; pe_valid = '0;
    tag_x = 4'd0; tag_y = 3'd0;
    pe_valid[9] = 1'b1; pe_word[9] = 32'h99999999;
    step();
    check_val("tables_zero", {16'h0, last_ready}, 64'h200);
    flush();

    // Randomized traffic with small ID alphabets so matches are frequent
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 249) == 0);
      set_xid = ($urandom_range(0, 7) == 0);
      xscan   = 4'($urandom_range(0, 3));
      set_yid = ($urandom_range(0, 7) == 0);
      yscan   = 3'($urandom_range(0, 1));
      tag_x   = 4'($urandom_range(0, 3));
      tag_y   = 3'($urandom_range(0, 1));
      glb_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NPE; i++) begin
        if (!pe_valid[i] && $urandom_range(0, 19) == 0) begin
          pe_valid[i] = 1'b1;
          pe_word[i]  = $urandom;
        end
      end
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
